// File: rtl/nihilist_pkg.sv
// Shared keyed-Polybius definitions for the Nihilist cipher blocks.
// Square is keyed with DANIEL, I and J share a cell, rows and columns run 1..5.
package nihilist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    localparam logic [8*25-1:0] SQUARE   = "DANIELBCFGHKMOPQRSTUVWXYZ";
    localparam int unsigned     ROW_MIN  = 1;
    localparam int unsigned     ROW_MAX  = 5;
    localparam int unsigned     COL_MIN  = 1;
    localparam int unsigned     COL_MAX  = 5;
    localparam logic [7:0]      BAD_CHAR = 8'h3F;

    // Case-insensitive; anything that is not a letter yields code 0.
    function automatic logic [7:0] letter_to_code(input logic [7:0] ch);
        logic [7:0] up;
        logic [7:0] code;
        up = (ch >= 8'h61 && ch <= 8'h7A) ? ch - 8'h20 : ch;
        if (up == 8'h4A) begin
            up = 8'h49;
        end
        code = 8'd0;
        for (int p = 0; p < 25; p++) begin
            if (SQUARE[8*(24-p) +: 8] == up) begin
                code = 8'(10 * (p / 5 + 1) + (p % 5) + 1);
            end
        end
        return code;
    endfunction

    function automatic logic [7:0] code_to_letter(input logic [7:0] code);
        int unsigned row;
        int unsigned col;
        row = 32'(code) / 32'd10;
        col = 32'(code) % 32'd10;
        if (row >= ROW_MIN && row <= ROW_MAX && col >= COL_MIN && col <= COL_MAX) begin
            return SQUARE[8*(24 - 5*(row-1) - (col-1)) +: 8];
        end
        return BAD_CHAR;
    endfunction

endpackage

// File: rtl/decrypt_stream_if.sv
// Cipher-in / plaintext-out valid-ready stream pair for decrypt_stream.
interface decrypt_stream_if;

    logic [7:0] i_w_cipher;
    logic       i_w_cipher_valid;
    logic       i_w_cipher_last;
    logic       o_r_cipher_ready;
    logic [7:0] o_r_text;
    logic       o_r_text_valid;
    logic       o_r_text_last;
    logic       i_w_text_ready;

    modport master (
        output i_w_cipher, i_w_cipher_valid, i_w_cipher_last, i_w_text_ready,
        input  o_r_cipher_ready, o_r_text, o_r_text_valid, o_r_text_last
    );

    modport slave (
        input  i_w_cipher, i_w_cipher_valid, i_w_cipher_last, i_w_text_ready,
        output o_r_cipher_ready, o_r_text, o_r_text_valid, o_r_text_last
    );

endinterface

// File: rtl/polybius_lookup.sv
// Combinational Polybius code to uppercase letter, with a flag for codes off the square.
module polybius_lookup
    import nihilist_pkg::*;
(
    input  logic [7:0] code_i,
    output logic [7:0] letter_o,
    output logic       valid_o
);

    always_comb begin
        letter_o = code_to_letter(code_i);
        valid_o  = (letter_o != BAD_CHAR);
    end

endmodule

// File: rtl/decrypt_stream.sv
// Streaming Nihilist decrypter: subtract the repeating key code, then look the difference up.
// Optional error outputs o_r_err / o_r_err_seen are built when DECRYPT_STREAM_ERR_EN is defined.
module decrypt_stream
    import nihilist_pkg::*;
#(
    parameter int p_secret_length = 6,
    parameter int p_idx_width     = 3
) (
    input  logic                         i_w_clk,
    input  logic                         i_w_rst,
    input  logic                         i_w_start,
    input  logic [p_secret_length*8-1:0] i_w_secret,
    decrypt_stream_if.slave              stream,
    output logic                         o_r_busy
`ifdef DECRYPT_STREAM_ERR_EN
    ,
    output logic                         o_r_err,
    output logic                         o_r_err_seen
`endif
);

    state_e                       state_q, state_d;
    logic [p_secret_length*8-1:0] secret_q, secret_d;
    logic [p_idx_width-1:0]       idx_q, idx_d;
    logic                         s1Valid_q, s1Valid_d;
    logic [7:0]                   s1Diff_q, s1Diff_d;
    logic                         s1Last_q, s1Last_d;
    logic                         s1Bad_q, s1Bad_d;
    logic                         s2Valid_q, s2Valid_d;
    logic [7:0]                   s2Text_q, s2Text_d;
    logic                         s2Last_q, s2Last_d;
`ifdef DECRYPT_STREAM_ERR_EN
    logic                         s2Err_q, s2Err_d;
    logic                         errSeen_q, errSeen_d;
`endif

    logic [7:0] keyChar;
    logic [7:0] keyCode;
    logic [7:0] lookupLetter;
    logic       lookupValid;
    logic       s2Advance;
    logic       s2Fire;
    logic       cipherReady;
    logic       accept;

    polybius_lookup u_lookup (
        .code_i   (s1Diff_q),
        .letter_o (lookupLetter),
        .valid_o  (lookupValid)
    );

    always_comb begin
        keyChar = '0;
        for (int i = 0; i < p_secret_length; i++) begin
            if (idx_q == p_idx_width'(i)) begin
                keyChar = secret_q[8*(p_secret_length-1-i) +: 8];
            end
        end
        keyCode = letter_to_code(keyChar);
    end

    // S2 drains when empty or taken downstream; S1 may refill in the same cycle it empties.
    assign s2Advance   = !s2Valid_q || stream.i_w_text_ready;
    assign s2Fire      = s2Valid_q && stream.i_w_text_ready;
    assign cipherReady = (state_q == ST_RUN) && (!s1Valid_q || s2Advance);
    assign accept      = cipherReady && stream.i_w_cipher_valid;

    always_comb begin
        state_d   = state_q;
        secret_d  = secret_q;
        idx_d     = idx_q;
        s1Valid_d = s1Valid_q;
        s1Diff_d  = s1Diff_q;
        s1Last_d  = s1Last_q;
        s1Bad_d   = s1Bad_q;
        s2Valid_d = s2Valid_q;
        s2Text_d  = s2Text_q;
        s2Last_d  = s2Last_q;
`ifdef DECRYPT_STREAM_ERR_EN
        s2Err_d   = s2Err_q;
        errSeen_d = errSeen_q;
        if (s2Fire && s2Err_q) begin
            errSeen_d = 1'b1;
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (i_w_start) begin
                    state_d  = ST_RUN;
                    secret_d = i_w_secret;
                    idx_d    = '0;
`ifdef DECRYPT_STREAM_ERR_EN
                    errSeen_d = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                if (accept && stream.i_w_cipher_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (s2Fire && s2Last_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            idx_d = (idx_q == p_idx_width'(p_secret_length - 1)) ? '0 : idx_q + 1'b1;
        end

        if (s2Advance) begin
            s2Valid_d = s1Valid_q;
            s2Text_d  = (s1Bad_q || !lookupValid) ? BAD_CHAR : lookupLetter;
            s2Last_d  = s1Last_q;
`ifdef DECRYPT_STREAM_ERR_EN
            s2Err_d   = s1Bad_q || !lookupValid;
`endif
            s1Valid_d = 1'b0;
        end

        // Unknown key chars and underflow are caught here; the lookup cannot see them.
        if (accept) begin
            s1Valid_d = 1'b1;
            s1Diff_d  = stream.i_w_cipher - keyCode;
            s1Last_d  = stream.i_w_cipher_last;
            s1Bad_d   = (keyCode == 8'd0) || (stream.i_w_cipher < keyCode);
        end
    end

    always_ff @(posedge i_w_clk) begin
        if (i_w_rst) begin
            state_q   <= ST_IDLE;
            secret_q  <= '0;
            idx_q     <= '0;
            s1Valid_q <= 1'b0;
            s1Diff_q  <= '0;
            s1Last_q  <= 1'b0;
            s1Bad_q   <= 1'b0;
            s2Valid_q <= 1'b0;
            s2Text_q  <= '0;
            s2Last_q  <= 1'b0;
`ifdef DECRYPT_STREAM_ERR_EN
            s2Err_q   <= 1'b0;
            errSeen_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            secret_q  <= secret_d;
            idx_q     <= idx_d;
            s1Valid_q <= s1Valid_d;
            s1Diff_q  <= s1Diff_d;
            s1Last_q  <= s1Last_d;
            s1Bad_q   <= s1Bad_d;
            s2Valid_q <= s2Valid_d;
            s2Text_q  <= s2Text_d;
            s2Last_q  <= s2Last_d;
`ifdef DECRYPT_STREAM_ERR_EN
            s2Err_q   <= s2Err_d;
            errSeen_q <= errSeen_d;
`endif
        end
    end

    assign stream.o_r_cipher_ready = cipherReady;
    assign stream.o_r_text         = s2Text_q;
    assign stream.o_r_text_valid   = s2Valid_q;
    assign stream.o_r_text_last    = s2Last_q;
    assign o_r_busy                = (state_q != ST_IDLE);
`ifdef DECRYPT_STREAM_ERR_EN
    assign o_r_err                 = s2Valid_q && s2Err_q;
    assign o_r_err_seen            = errSeen_q;
`endif

endmodule

// File: tb/tb_decrypt_stream.sv
// Self-checking bench for decrypt_stream: directed messages plus randomized traffic against a string-table model.
module tb_decrypt_stream;

    localparam int SLEN = 6;

    typedef struct {
        byte unsigned ch;
        bit           last;
        int           acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [SLEN*8-1:0] secret;
    logic             busy;
`ifdef DECRYPT_STREAM_ERR_EN
    logic             err;
    logic             errSeen;
    bit               errSeenM = 1'b0;
`endif

    decrypt_stream_if sif ();

    decrypt_stream #(
        .p_secret_length (SLEN),
        .p_idx_width     (3)
    ) dut (
        .i_w_clk    (clk),
        .i_w_rst    (rst),
        .i_w_start  (start),
        .i_w_secret (secret),
        .stream     (sif.slave),
        .o_r_busy   (busy)
`ifdef DECRYPT_STREAM_ERR_EN
        ,
        .o_r_err      (err),
        .o_r_err_seen (errSeen)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          readyMode = 0;
    bit          latChk = 1'b0;
    int          waitSum = 0;
    string       gotStr = "";
    exp_t        expQ[$];
    string       rows[5] = '{"DANIE", "LBCFG", "HKMOP", "QRSTU", "VWXYZ"};

    function automatic int keyValue(input byte unsigned ch);
        byte unsigned u;
        u = ch;
        if (u >= "a" && u <= "z") u = u - 8'd32;
        if (u == "J") u = "I";
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                if (rows[r][c] == u) return 10 * (r + 1) + c + 1;
        return 0;
    endfunction

    function automatic byte unsigned modelChar(input byte unsigned cipher, input byte unsigned keyCh);
        int k;
        int d;
        k = keyValue(keyCh);
        if (k == 0 || int'(cipher) < k) return 8'h3F;
        d = int'(cipher) - k;
        if (d / 10 < 1 || d / 10 > 5 || d % 10 < 1 || d % 10 > 5) return 8'h3F;
        return rows[d / 10 - 1][d % 10 - 1];
    endfunction

    task automatic checkOutput(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic checkText(input string name, input string got, input string exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("[TB] FAIL %s: got \"%s\" expected \"%s\"", name, got, exp);
        end
    endtask

    // Downstream ready: 0 = held high, 1 = held low, otherwise random.
    initial begin : readyDriver
        sif.i_w_text_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       sif.i_w_text_ready = 1'b1;
                1:       sif.i_w_text_ready = 1'b0;
                default: sif.i_w_text_ready = ($urandom % 4) != 0;
            endcase
        end
    end

    // Compare process: observes both handshakes mid-cycle and scores the output stream.
    initial begin : monitor
        logic [SLEN*8-1:0] secretM;
        int                idxM;
        bit                prevStall;
        byte unsigned      prevText;
        bit                prevLast;
        exp_t              e;
        secretM   = '0;
        idxM      = 0;
        prevStall = 1'b0;
        prevText  = 8'h00;
        prevLast  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
`ifdef DECRYPT_STREAM_ERR_EN
            checkOutput("errSeen", int'(errSeen), int'(errSeenM));
`endif
            if (rst) begin
                expQ.delete();
                idxM      = 0;
                prevStall = 1'b0;
`ifdef DECRYPT_STREAM_ERR_EN
                errSeenM  = 1'b0;
`endif
                continue;
            end
            if (prevStall) begin
                checkOutput("holdValid", int'(sif.o_r_text_valid), 1);
                checkOutput("holdText", int'(sif.o_r_text), int'(prevText));
                checkOutput("holdLast", int'(sif.o_r_text_last), int'(prevLast));
            end
            if (sif.o_r_text_valid && sif.i_w_text_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("spuriousChar", int'(sif.o_r_text), -1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("text", int'(sif.o_r_text), int'(e.ch));
                    checkOutput("textLast", int'(sif.o_r_text_last), int'(e.last));
                    if (latChk) checkOutput("latency", cyc - e.acc, 2);
`ifdef DECRYPT_STREAM_ERR_EN
                    checkOutput("errFlag", int'(err), int'(e.ch == 8'h3F));
                    if (e.ch == 8'h3F) errSeenM = 1'b1;
`endif
                end
                gotStr = $sformatf("%s%c", gotStr, sif.o_r_text);
            end
            if (start) begin
                secretM = secret;
                idxM    = 0;
`ifdef DECRYPT_STREAM_ERR_EN
                errSeenM = 1'b0;
`endif
            end
            if (sif.i_w_cipher_valid && sif.o_r_cipher_ready) begin
                e.ch   = modelChar(sif.i_w_cipher, secretM[8*(SLEN-1-idxM) +: 8]);
                e.last = sif.i_w_cipher_last;
                e.acc  = cyc;
                expQ.push_back(e);
                idxM = (idxM + 1) % SLEN;
            end
            prevStall = sif.o_r_text_valid && !sif.i_w_text_ready;
            prevText  = sif.o_r_text;
            prevLast  = sif.o_r_text_last;
        end
    end

    task automatic startMsg(input logic [SLEN*8-1:0] s);
        @(posedge clk);
        #1;
        secret = s;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic sendByte(input byte unsigned b, input bit last, input int gap);
        int waited;
        waited = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        sif.i_w_cipher       = b;
        sif.i_w_cipher_valid = 1'b1;
        sif.i_w_cipher_last  = last;
        @(negedge clk);
        while (!sif.o_r_cipher_ready && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        checkOutput("acceptInTime", int'(waited < 300), 1);
        waitSum += waited;
        @(posedge clk);
        #1;
        sif.i_w_cipher_valid = 1'b0;
        sif.i_w_cipher_last  = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            n++;
            @(negedge clk);
        end
        checkOutput("busyDropped", int'(busy), 0);
        checkOutput("idleNotReady", int'(sif.o_r_cipher_ready), 0);
        checkOutput("nothingPending", expQ.size(), 0);
    endtask

    task automatic applyStimulus(input logic [SLEN*8-1:0] s, input byte unsigned msg[$], input int maxGap);
        gotStr  = "";
        waitSum = 0;
        startMsg(s);
        for (int i = 0; i < msg.size(); i++) begin
            sendByte(msg[i], i == msg.size() - 1, (maxGap > 0) ? $urandom_range(0, maxGap) : 0);
        end
        waitIdle();
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        byte unsigned      topMsg[$];
        byte unsigned      msg[$];
        logic [SLEN*8-1:0] s;
        byte unsigned      ch;
        int                n;

        topMsg = '{55, 46, 48, 57, 36, 35, 53, 27, 57};
        rst                  = 1'b1;
        start                = 1'b0;
        secret               = '0;
        sif.i_w_cipher       = 8'h00;
        sif.i_w_cipher_valid = 1'b0;
        sif.i_w_cipher_last  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstTextValid", int'(sif.o_r_text_valid), 0);
        checkOutput("rstText", int'(sif.o_r_text), 0);
        checkOutput("rstTextLast", int'(sif.o_r_text_last), 0);
        checkOutput("rstCipherReady", int'(sif.o_r_cipher_ready), 0);
        checkOutput("rstBusy", int'(busy), 0);
        rst = 1'b0;

        checkOutput("pinKeyJ", keyValue("J"), 14);
        checkOutput("pinKeyT", keyValue("t"), 44);
        checkOutput("pinT", int'(modelChar(55, "D")), int'("T"));
        checkOutput("pinUnderflow", int'(modelChar(10, "D")), 8'h3F);
        checkOutput("pinRow6", int'(modelChar(71, "D")), 8'h3F);
        checkOutput("pinI", int'(modelChar(26, "a")), int'("I"));

        latChk = 1'b1;
        applyStimulus("DANILA", topMsg, 0);
        checkText("topSecret", gotStr, "TOPSECRET");

        msg = '{23, 24, 25, 26, 33, 24, 23, 24, 25, 26};
        applyStimulus("DANILA", msg, 0);
        checkText("keyWrap", gotStr, "AAAAAAAAAA");
        checkOutput("backToBackStalls", waitSum, 0);

        msg = '{10, 71};
        applyStimulus("DDDDDD", msg, 0);
        checkText("invalidCodes", gotStr, "??");
        msg = '{26};
        applyStimulus("AAAAAA", msg, 0);
        checkText("mergedIJ", gotStr, "I");
        applyStimulus("danila", topMsg, 0);
        checkText("lowerSecret", gotStr, "TOPSECRET");
        latChk = 1'b0;

        fork
            applyStimulus("DANILA", topMsg, 0);
            begin
                repeat (4) @(posedge clk);
                @(posedge clk);
                #2;
                readyMode = 1;
                repeat (3) @(negedge clk);
                checkOutput("stallReadyLow", int'(sif.o_r_cipher_ready), 0);
                checkOutput("stallTextHeld", int'(sif.o_r_text_valid), 1);
                repeat (2) @(negedge clk);
                readyMode = 0;
            end
        join
        checkText("stallNoLoss", gotStr, "TOPSECRET");

        readyMode = 1;
        startMsg("DANILA");
        sendByte(55, 1'b0, 0);
        sendByte(46, 1'b0, 0);
        @(negedge clk);
        checkOutput("inFlightBeforeReset", int'(sif.o_r_text_valid), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midRstTextValid", int'(sif.o_r_text_valid), 0);
        checkOutput("midRstText", int'(sif.o_r_text), 0);
        checkOutput("midRstTextLast", int'(sif.o_r_text_last), 0);
        checkOutput("midRstCipherReady", int'(sif.o_r_cipher_ready), 0);
        checkOutput("midRstBusy", int'(busy), 0);
        rst = 1'b0;
        readyMode = 0;
        @(negedge clk);
        latChk = 1'b1;
        applyStimulus("DANILA", topMsg, 0);
        checkText("afterReset", gotStr, "TOPSECRET");
        latChk = 1'b0;

        readyMode = 2;
        for (int m = 0; m < 12; m++) begin
            for (int i = 0; i < SLEN; i++) begin
                ch = 8'($urandom_range(0, 25)) + 8'h41;
                if ($urandom % 3 == 0) ch = ch + 8'h20;
                if ($urandom % 10 == 0) ch = "7";
                s[8*(SLEN-1-i) +: 8] = ch;
            end
            n = $urandom_range(1, 16);
            msg.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom % 4 != 0)
                    msg.push_back(8'(keyValue(s[8*(SLEN-1-(i % SLEN)) +: 8])
                                     + 10 * $urandom_range(1, 5) + $urandom_range(1, 5)));
                else
                    msg.push_back(8'($urandom_range(0, 255)));
            end
            applyStimulus(s, msg, 2);
        end
        readyMode = 0;

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decrypt_stream.md
Name: decrypt_stream

Overview:
- Streaming inverse of the combinational `encrypt` block: recovers plaintext letters from a Nihilist-style cipher, one cipher byte per cycle.
- The cipher is the sum of keyed-Polybius codes of the text char and the repeating secret char.
- Sits on the receive side: consumes cipher bytes over a valid/ready stream and emits uppercase ASCII plaintext over a valid/ready stream.
- Square (key DANIEL, I/J merged), rows 1-5:
  - DANIE
  - LBCFG
  - HKMOP
  - QRSTU
  - VWXYZ
- code = 10*row + col, e.g. D=11, A=12, L=21, T=44.

Parameters:
- p_secret_length, 6, number of secret characters (≥1).
- p_idx_width, 3, width of key index counter; must satisfy 2**p_idx_width ≥ p_secret_length.

Ports:
- i_w_clk  in  1  clock, rising edge.
- i_w_rst  in  1  reset, synchronous, active-high.
- i_w_start  in  1  pulse: latch i_w_secret, clear key index, enter RUN.
- i_w_secret  in  p_secret_length*8  ASCII secret; first char in MSB byte.
- i_w_cipher  in  8  cipher byte (binary sum).
- i_w_cipher_valid  in  1  cipher byte valid.
- i_w_cipher_last  in  1  marks final byte of message.
- o_r_cipher_ready  out  1  block accepts byte this cycle.
- o_r_text  out  8  recovered uppercase ASCII char.
- o_r_text_valid  out  1  o_r_text valid.
- i_w_text_ready  in  1  downstream accepts char.
- o_r_text_last  out  1  accompanies char from last cipher byte.
- o_r_busy  out  1  high in RUN or DRAIN.

Behaviour:
- Reset: all outputs 0; state IDLE; key register 0; key index 0; pipeline valids 0.
- Reset takes priority over every other input, including mid-message; in-flight data is discarded.
- FSM states and transitions:
  - IDLE → RUN on i_w_start.
  - RUN → DRAIN on accepting a byte with i_w_cipher_last=1.
  - DRAIN → IDLE when the last char handshakes out.
- i_w_start is ignored outside IDLE.
- o_r_cipher_ready is 1 only in RUN, and only when stage 1 is empty or will advance this cycle.
- A byte is accepted when valid && ready.
- Pipeline, 2 stages:
  - S1 registers diff = cipher − keycode(secret[idx]), the last flag, and an underflow flag.
  - S2 registers the letter lookup of diff.
- Latency: byte accepted at edge N → o_r_text_valid at edge N+2 when downstream is ready.
- Stalls: when o_r_text_valid && !i_w_text_ready, S2 holds, S1 holds if full, and ready drops. No byte is lost or duplicated.
- Output stability: o_r_text, o_r_text_last and o_r_text_valid stay stable until handshaken.
- Key index: advances only on an accepted byte, wrapping from p_secret_length−1 to 0. Each message starts at 0.
- Key char mapping:
  - Letters are case-insensitive; J maps to 14.
  - A non-letter key char gives code 0 and is flagged invalid.
- Arithmetic: 8-bit unsigned. cipher < keycode is underflow and invalid.
- Lookup: diff is valid iff its tens digit (row) is 1..5 and its units digit (col) is 1..5. Otherwise the result is invalid.
- Valid output is the uppercase letter. Code 14 yields 'I', never 'J'.
- Invalid output: 8'h3F ('?').
- Back-to-back throughput: 1 char/cycle with i_w_text_ready held high.

Optional Feature:
- Macro: DECRYPT_STREAM_ERR_EN.
- When defined:
  - Adds output o_r_err (1 bit), asserted alongside any '?' char and handshaken with it.
  - Adds sticky o_r_err_seen, cleared only by reset or i_w_start.
- When undefined:
  - Neither port exists.
  - '?' substitution is unchanged.

Decomposition:
- Package nihilist_pkg holds:
  - square constant (25 ASCII letters, row-major);
  - localparams for row/col bounds and the '?' code;
  - function letter_to_code (ASCII→8-bit code, 0 if invalid);
  - function code_to_letter.
- One sub-module, polybius_lookup: combinational code→letter with valid flag, instantiated in S2.
- FSM, index counter and pipeline stay in decrypt_stream.

Test Plan:
- Start with secret "DANILA", then stream 55,46,48,57,36,35,53,27,57 (last on 57) → "TOPSECRET", o_r_text_last on final 'T', first char 2 cycles after first accept, busy drops after drain.
- Secret "DANILA", 10 bytes from repeating 12+11=23 → 'A' each cycle → key index wraps after 6. Byte 7 uses D(11), so 23 decodes to 'A'. Throughput 1/cycle.
- Cipher 10 with key char D (11) → underflow → '?'. Cipher 71 with key D → diff 60, row 6 → '?'. With DANIEL_STREAM… with DECRYPT_STREAM_ERR_EN defined, o_r_err=1 on each and o_r_err_seen stays set.
- Hold i_w_text_ready=0 for 5 cycles mid-stream → o_r_text stable, o_r_cipher_ready drops within 1 cycle, no loss or duplication after release.
- Assert i_w_rst while 2 chars are in flight → next cycle all outputs 0, state IDLE. A new start/stream decodes correctly from key index 0.
- Lowercase secret "danila" with "TOPSECRET" cipher → same output. Cipher 14+12 with key 'A' → 'I'.
